// File: rtl/sdram_pkg.sv
// Shared SDRAM write-path definitions: command encodings {cs_n,ras_n,cas_n,we_n}
// and the burst-writer state enum.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_WRITE      = 4'b0100;
  localparam logic [3:0] CMD_BURST_TERM = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

  // Address line that selects auto-precharge on WRITE and all-banks on PRECHARGE.
  localparam int A10_BIT = 10;

  typedef enum logic [3:0] {
    IDLE,
    ACT,
    TRCD_W,
    WRITE,
    DATA,
    TERM,
    PRE,
    TRP_W,
    END
  } wr_state_t;

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// Bank/row/column address counter for the burst writer. Each step advances the
// column; a column wrap carries into the row, and a row wrap carries into the bank.
module sdram_wr_addr_gen #(
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   load_addr,
  input  logic                            step,
  output logic [BANK_W-1:0]               bank,
  output logic [ROW_W-1:0]                row,
  output logic [COL_W-1:0]                col,
  output logic                            col_last
);

  assign col_last = &col;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank <= '0;
      row  <= '0;
      col  <= '0;
    end else if (load) begin
      {bank, row, col} <= load_addr;
    end else if (step) begin
      col <= col + 1'b1;
      if (col_last) begin
        row <= row + 1'b1;
        if (&row) bank <= bank + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_burst_writer.sv
// Full-page SDRAM burst writer: ACTIVE, WRITE + N data words, BURST_TERM, PRECHARGE.
// Define SDRAM_WR_PAGE_CROSS_EN to continue bursts across page ends onto the next row.
module sdram_burst_writer
  import sdram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int TRCD   = 2,
  parameter int TRP    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [BANK_W+ROW_W+COL_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [COL_W:0]                wr_burst_len,
  output logic [3:0]                    wr_cmd,
  output logic [BANK_W-1:0]             wr_bank_addr,
  output logic [ROW_W-1:0]              wr_sdram_addr,
  output logic [DATA_W-1:0]             wr_sdram_data,
  output logic                          wr_sdram_en,
  output logic                          wr_ack,
  output logic                          wr_end
);

  // Wait-state exit values for a counter that starts at 0 on entry. The END cycle
  // is itself a NOP, so the finishing path spends one cycle fewer in TRP_W.
  localparam int TRCD_HOLD       = (TRCD > 2) ? TRCD - 2 : 0;
  localparam int TRP_RESUME_HOLD = (TRP  > 2) ? TRP  - 2 : 0;
  localparam int TRP_END_HOLD    = (TRP  > 3) ? TRP  - 3 : 0;

  wr_state_t           state, next_state;
  logic [7:0]          wait_cnt;
  logic [COL_W:0]      remaining;
  logic [BANK_W-1:0]   cur_bank;
  logic [ROW_W-1:0]    cur_row;
  logic [COL_W-1:0]    cur_col;
  logic                col_last;
  logic                last_word;
  logic                resume;
  logic                start;

  assign start     = (state == IDLE) && wr_en;
  assign last_word = (remaining == {{COL_W{1'b0}}, 1'b1});

`ifdef SDRAM_WR_PAGE_CROSS_EN
  assign resume = (remaining != '0);
`else
  assign resume = 1'b0;
`endif

  sdram_wr_addr_gen #(
    .BANK_W (BANK_W),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start),
    .load_addr (wr_addr),
    .step      (wr_ack),
    .bank      (cur_bank),
    .row       (cur_row),
    .col       (cur_col),
    .col_last  (col_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      remaining <= '0;
    end else begin
      if (next_state != state)                     wait_cnt <= '0;
      else if (state == TRCD_W || state == TRP_W)  wait_cnt <= wait_cnt + 8'd1;

      if (start)       remaining <= wr_burst_len;
      else if (wr_ack) remaining <= remaining - 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:        if (wr_en) next_state = (wr_burst_len == '0) ? END : ACT;
      ACT:         next_state = (TRCD > 1) ? TRCD_W : WRITE;
      TRCD_W:      if (wait_cnt == 8'(TRCD_HOLD)) next_state = WRITE;
      WRITE, DATA: next_state = (last_word || col_last) ? TERM : DATA;
      TERM:        next_state = PRE;
      PRE: begin
        if (resume) next_state = (TRP > 1) ? TRP_W : ACT;
        else        next_state = (TRP > 2) ? TRP_W : END;
      end
      TRP_W: begin
        if (resume && wait_cnt == 8'(TRP_RESUME_HOLD))    next_state = ACT;
        else if (!resume && wait_cnt == 8'(TRP_END_HOLD)) next_state = END;
      end
      END:         next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // NOTE: every output takes a default before the case so no path infers a latch.
  always_comb begin
    wr_cmd        = CMD_NOP;
    wr_bank_addr  = '0;
    wr_sdram_addr = '0;
    wr_sdram_en   = 1'b0;
    wr_ack        = 1'b0;
    wr_end        = 1'b0;
    unique case (state)
      ACT: begin
        wr_cmd        = CMD_ACTIVE;
        wr_bank_addr  = cur_bank;
        wr_sdram_addr = cur_row;
      end
      WRITE: begin
        wr_cmd                 = CMD_WRITE;
        wr_bank_addr           = cur_bank;
        wr_sdram_addr          = ROW_W'(cur_col);
        wr_sdram_addr[A10_BIT] = 1'b0;
        wr_sdram_en            = 1'b1;
        wr_ack                 = 1'b1;
      end
      DATA: begin
        wr_sdram_en = 1'b1;
        wr_ack      = 1'b1;
      end
      TERM: wr_cmd = CMD_BURST_TERM;
      PRE: begin
        wr_cmd                 = CMD_PRECHARGE;
        wr_sdram_addr[A10_BIT] = 1'b1;
      end
      END:     wr_end = 1'b1;
      default: ;
    endcase
  end

  assign wr_sdram_data = wr_sdram_en ? wr_data : '0;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Self-checking bench for sdram_burst_writer: randomized bursts against a
// cycle-trace reference model built from the command-sequence rules.
module tb_sdram_burst_writer;

  localparam int DATA_W = 16;
  localparam int BANK_W = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
  localparam int TRCD   = 2;
  localparam int TRP    = 2;
  localparam int PAGE   = 1 << COL_W;
  localparam int ROWS   = 1 << ROW_W;
  localparam int BANKS  = 1 << BANK_W;
`ifdef SDRAM_WR_PAGE_CROSS_EN
  localparam bit CROSS = 1'b1;
`else
  localparam bit CROSS = 1'b0;
`endif

  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_TERM  = 4'b0110;
  localparam logic [3:0] C_PRE   = 4'b0010;

  // kind: 0 = no address check, 1 = ACTIVE bank/row, 2 = WRITE bank/col, 3 = PRECHARGE A10
  typedef struct {
    logic [3:0] cmd;
    bit         ack;
    bit         fin;
    int         kind;
    int         bank;
    int         addr;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          wr_en = 1'b0;
  logic [BANK_W+ROW_W+COL_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0]             wr_data = '0;
  logic [COL_W:0]                wr_burst_len = '0;
  logic [3:0]                    wr_cmd;
  logic [BANK_W-1:0]             wr_bank_addr;
  logic [ROW_W-1:0]              wr_sdram_addr;
  logic [DATA_W-1:0]             wr_sdram_data;
  logic                          wr_sdram_en;
  logic                          wr_ack;
  logic                          wr_end;

  exp_t exp_q[$];
  int   act_log[$];
  int   ack_seen;
  int   end_seen;
  int   passed = 0;
  int   total  = 0;

  sdram_burst_writer #(
    .DATA_W (DATA_W), .BANK_W (BANK_W), .ROW_W (ROW_W), .COL_W (COL_W),
    .TRCD   (TRCD),   .TRP    (TRP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_burst_len  (wr_burst_len),
    .wr_cmd        (wr_cmd),
    .wr_bank_addr  (wr_bank_addr),
    .wr_sdram_addr (wr_sdram_addr),
    .wr_sdram_data (wr_sdram_data),
    .wr_sdram_en   (wr_sdram_en),
    .wr_ack        (wr_ack),
    .wr_end        (wr_end)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic exp_t mk(logic [3:0] cmd, bit ack, bit fin, int kind, int bank, int addr);
    exp_t e;
    e.cmd = cmd; e.ack = ack; e.fin = fin; e.kind = kind; e.bank = bank; e.addr = addr;
    return e;
  endfunction

  // Expected per-cycle trace starting with the cycle after wr_en is sampled.
  task automatic build_model(input int b0, input int r0, input int c0, input int n);
    int b = b0, r = r0, c = c0, left = n;
    bit first, done = 1'b0;
    exp_q.delete();
    if (n == 0) begin
      exp_q.push_back(mk(C_NOP, 0, 1, 0, 0, 0));
      return;
    end
    while (!done) begin
      exp_q.push_back(mk(C_ACT, 0, 0, 1, b, r));
      for (int i = 1; i < TRCD; i++) exp_q.push_back(mk(C_NOP, 0, 0, 0, 0, 0));
      first = 1'b1;
      while (left > 0 && c < PAGE) begin
        exp_q.push_back(mk(first ? C_WRITE : C_NOP, 1, 0, first ? 2 : 0, b, c));
        first = 1'b0;
        left--;
        c++;
      end
      if (c == PAGE) begin
        c = 0;
        r++;
        if (r == ROWS) begin r = 0; b = (b + 1) % BANKS; end
      end
      exp_q.push_back(mk(C_TERM, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(C_PRE, 0, 0, 3, 0, 0));
      if (left > 0 && CROSS) begin
        for (int i = 1; i < TRP; i++) exp_q.push_back(mk(C_NOP, 0, 0, 0, 0, 0));
      end else begin
        for (int i = 2; i < TRP; i++) exp_q.push_back(mk(C_NOP, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(C_NOP, 0, 1, 0, 0, 0));
        done = 1'b1;
      end
    end
  endtask

  // Called at negedge+1 with the DUT idle; runs one request and compares every cycle.
  task automatic run_burst(input string tag, input int b, input int r, input int c, input int n);
    build_model(b, r, c, n);
    ack_seen = 0;
    end_seen = 0;
    act_log.delete();
    wr_en        = 1'b1;
    wr_addr      = {BANK_W'(b), ROW_W'(r), COL_W'(c)};
    wr_burst_len = (COL_W+1)'(n);
    foreach (exp_q[i]) begin
      @(negedge clk);
      wr_en        = 1'($urandom_range(0, 1));
      wr_addr      = (BANK_W+ROW_W+COL_W)'($urandom);
      wr_burst_len = (COL_W+1)'($urandom);
      wr_data      = DATA_W'($urandom);
      #1;
      total++;
      if ({wr_cmd, wr_ack, wr_sdram_en, wr_end} !== {exp_q[i].cmd, exp_q[i].ack, exp_q[i].ack, exp_q[i].fin}) begin
        $display("FAIL %s cyc%0d ctrl: got cmd=%b ack=%b en=%b end=%b, want cmd=%b ack=%b en=%b end=%b",
                 tag, i, wr_cmd, wr_ack, wr_sdram_en, wr_end,
                 exp_q[i].cmd, exp_q[i].ack, exp_q[i].ack, exp_q[i].fin);
      end else passed++;
      if (exp_q[i].kind == 1) begin
        total++;
        if (wr_bank_addr !== BANK_W'(exp_q[i].bank) || wr_sdram_addr !== ROW_W'(exp_q[i].addr)) begin
          $display("FAIL %s cyc%0d active addr: got bank=%0d row=%0d, want bank=%0d row=%0d",
                   tag, i, wr_bank_addr, wr_sdram_addr, exp_q[i].bank, exp_q[i].addr);
        end else passed++;
      end
      if (exp_q[i].kind == 2) begin
        total++;
        if (wr_bank_addr !== BANK_W'(exp_q[i].bank) || wr_sdram_addr[COL_W-1:0] !== COL_W'(exp_q[i].addr)
            || wr_sdram_addr[10] !== 1'b0) begin
          $display("FAIL %s cyc%0d write addr: got bank=%0d col=%0d a10=%b, want bank=%0d col=%0d a10=0",
                   tag, i, wr_bank_addr, wr_sdram_addr[COL_W-1:0], wr_sdram_addr[10],
                   exp_q[i].bank, exp_q[i].addr);
        end else passed++;
      end
      if (exp_q[i].kind == 3) begin
        total++;
        if (wr_sdram_addr[10] !== 1'b1) begin
          $display("FAIL %s cyc%0d precharge a10: got %b, want 1", tag, i, wr_sdram_addr[10]);
        end else passed++;
      end
      if (exp_q[i].ack) begin
        total++;
        if (wr_sdram_data !== wr_data) begin
          $display("FAIL %s cyc%0d dq data: got %h, want %h", tag, i, wr_sdram_data, wr_data);
        end else passed++;
      end
      if (wr_ack === 1'b1) ack_seen++;
      if (wr_end === 1'b1) end_seen++;
      if (wr_cmd === C_ACT) act_log.push_back(int'(wr_bank_addr) * ROWS + int'(wr_sdram_addr));
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    total++;
    if (wr_cmd !== C_NOP || wr_ack !== 1'b0 || wr_end !== 1'b0) begin
      $display("FAIL %s after-end idle: got cmd=%b ack=%b end=%b, want cmd=%b ack=0 end=0",
               tag, wr_cmd, wr_ack, wr_end, C_NOP);
    end else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b1;
    wr_burst_len = 10'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({wr_cmd, wr_ack, wr_sdram_en, wr_end} !== {C_NOP, 3'b000}) begin
      $display("FAIL reset ctrl: got cmd=%b ack=%b en=%b end=%b, want cmd=%b ack=0 en=0 end=0",
               wr_cmd, wr_ack, wr_sdram_en, wr_end, C_NOP);
    end else passed++;
    total++;
    if (wr_bank_addr !== '0 || wr_sdram_addr !== '0 || wr_sdram_data !== '0) begin
      $display("FAIL reset buses: got bank=%0d addr=%0d data=%h, want all 0",
               wr_bank_addr, wr_sdram_addr, wr_sdram_data);
    end else passed++;
    wr_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (wr_cmd !== C_NOP || wr_end !== 1'b0 || dut.state !== sdram_pkg::IDLE) begin
      $display("FAIL reset release idle: got cmd=%b end=%b state=%0d, want cmd=%b end=0 state=IDLE",
               wr_cmd, wr_end, dut.state, C_NOP);
    end else passed++;
  endtask

  task automatic test_basic();
    run_burst("basic", 0, 0, 0, 4);
    total++;
    if (ack_seen !== 4 || end_seen !== 1) begin
      $display("FAIL basic counts: got acks=%0d ends=%0d, want acks=4 ends=1", ack_seen, end_seen);
    end else passed++;
  endtask

  task automatic test_zero_len();
    run_burst("zero_len", int'($urandom_range(0, BANKS-1)), int'($urandom_range(0, ROWS-1)),
              int'($urandom_range(0, PAGE-1)), 0);
    total++;
    if (ack_seen !== 0 || end_seen !== 1 || act_log.size() !== 0) begin
      $display("FAIL zero_len counts: got acks=%0d ends=%0d acts=%0d, want acks=0 ends=1 acts=0",
               ack_seen, end_seen, act_log.size());
    end else passed++;
  endtask

  task automatic test_page_cross();
    int b = int'($urandom_range(0, BANKS-1));
    int r = int'($urandom_range(0, ROWS-2));
    int want_acks = CROSS ? 4 : 2;
    int want_acts = CROSS ? 2 : 1;
    int want_last = b * ROWS + (CROSS ? r + 1 : r);
    run_burst("page_cross", b, r, PAGE - 2, 4);
    total++;
    if (ack_seen !== want_acks || end_seen !== 1 || act_log.size() !== want_acts || act_log[$] !== want_last) begin
      $display("FAIL page_cross: got acks=%0d ends=%0d acts=%0d last_act=%0d, want acks=%0d ends=1 acts=%0d last_act=%0d",
               ack_seen, end_seen, act_log.size(), act_log[$], want_acks, want_acts, want_last);
    end else passed++;
  endtask

  task automatic test_bank_wrap();
    int want_last = CROSS ? 0 : (BANKS - 1) * ROWS + (ROWS - 1);
    int want_acks = CROSS ? 3 : 1;
    run_burst("bank_wrap", BANKS - 1, ROWS - 1, PAGE - 1, 3);
    total++;
    if (ack_seen !== want_acks || act_log[$] !== want_last) begin
      $display("FAIL bank_wrap: got acks=%0d last_act=%0d, want acks=%0d last_act=%0d",
               ack_seen, act_log[$], want_acks, want_last);
    end else passed++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      int c = ($urandom_range(0, 1) == 1) ? PAGE - 1 - int'($urandom_range(0, 5)) : int'($urandom_range(0, PAGE-1));
      run_burst($sformatf("random%0d", k), int'($urandom_range(0, BANKS-1)),
                int'($urandom_range(0, ROWS-1)), c, int'($urandom_range(0, 24)));
    end
  endtask

  task automatic test_reset_mid_burst();
    wr_en        = 1'b1;
    wr_addr      = {BANK_W'(1), ROW_W'(77), COL_W'(5)};
    wr_burst_len = 10'd8;
    repeat (TRCD + 2) begin
      @(negedge clk);
      wr_en = 1'b0;
      wr_data = DATA_W'($urandom);
    end
    #1;
    total++;
    if (wr_ack !== 1'b1 || wr_cmd !== C_NOP) begin
      $display("FAIL mid_reset pre-check: got ack=%b cmd=%b, want ack=1 cmd=%b", wr_ack, wr_cmd, C_NOP);
    end else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({wr_cmd, wr_ack, wr_sdram_en, wr_end} !== {C_NOP, 3'b000} || dut.state !== sdram_pkg::IDLE) begin
      $display("FAIL mid_reset: got cmd=%b ack=%b en=%b end=%b state=%0d, want cmd=%b ack=0 en=0 end=0 state=IDLE",
               wr_cmd, wr_ack, wr_sdram_en, wr_end, dut.state, C_NOP);
    end else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (wr_cmd !== C_NOP || wr_ack !== 1'b0 || wr_end !== 1'b0) begin
        $display("FAIL mid_reset recovery cyc%0d: got cmd=%b ack=%b end=%b, want cmd=%b ack=0 end=0",
                 i, wr_cmd, wr_ack, wr_end, C_NOP);
      end else passed++;
    end
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_a", 2, 100, 30, 6);
    run_burst("b2b_b", 0, 5, PAGE - 3, 7);
    run_burst("b2b_c", 3, 9, 0, 0);
    run_burst("b2b_d", 1, 4000, 200, 1);
    total++;
    if (ack_seen !== 1 || end_seen !== 1) begin
      $display("FAIL b2b single word: got acks=%0d ends=%0d, want acks=1 ends=1", ack_seen, end_seen);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_page_cross();
    test_bank_wrap();
    test_random();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
